// File: rtl/counter_cmd_sequencer.sv
//==============================================================================
// Module  : counter_cmd_sequencer
// Brief   : Command-driven controller for a loadable up/down counter; runs
//           LOAD / UP N / DOWN N / CLEAR and reports final Q and Co events.
// Revision: 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module counter_cmd_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_abort,
    output logic [WIDTH-1:0] cnt_D,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic             cnt_up,
    output logic             cnt_clr_n,
    input  logic [WIDTH-1:0] cnt_Q,
    input  logic             cnt_Co,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] wraps,
    output logic             aborted
);

    localparam logic [1:0] c_OP_LOAD  = 2'b00;
    localparam logic [1:0] c_OP_UP    = 2'b01;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_CL     = 3'd2,
        S_STEP   = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic [WIDTH-1:0] wraps_acc_q, wraps_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] wraps_q, wraps_d;
    logic             aborted_q, aborted_d;
    logic             w_step_en;

    // Abort is the only input allowed to reach a counter control combinationally.
    assign w_step_en  = (state_q == S_STEP) && !cmd_abort;

    assign cmd_ready  = (state_q == S_IDLE);
    assign cnt_load   = (state_q == S_LD);
    assign cnt_enable = (state_q == S_LD) || w_step_en;
    assign cnt_up     = (state_q == S_STEP) && (op_q == c_OP_UP);
    assign cnt_clr_n  = (state_q != S_CL);
    assign cnt_D      = (state_q == S_LD) ? data_q : '0;
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign wraps      = wraps_q;
    assign aborted    = aborted_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        remain_d    = remain_q;
        wraps_acc_d = wraps_acc_q;
        result_d    = result_q;
        wraps_d     = wraps_q;
        aborted_d   = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    data_d      = cmd_data;
                    remain_d    = cmd_data;
                    wraps_acc_d = '0;
                    aborted_d   = 1'b0;
                    if (cmd_op == c_OP_LOAD)       state_d = S_LD;
                    else if (cmd_op == c_OP_CLEAR) state_d = S_CL;
                    else if (cmd_data != '0)       state_d = S_STEP;
                    else                           state_d = S_SETTLE;
                end
            end
            S_LD:     state_d = S_SETTLE;
            S_CL:     state_d = S_SETTLE;
            S_STEP: begin
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_SETTLE;
                end else begin
                    remain_d = remain_q - WIDTH'(1);
                    if (cnt_Co && w_step_en && (wraps_acc_q != '1))
                        wraps_acc_d = wraps_acc_q + WIDTH'(1);
                    if (remain_q == WIDTH'(1))
                        state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                result_d = cnt_Q;
                wraps_d  = wraps_acc_q;
                state_d  = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            remain_q    <= '0;
            wraps_acc_q <= '0;
            result_q    <= '0;
            wraps_q     <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            remain_q    <= remain_d;
            wraps_acc_q <= wraps_acc_d;
            result_q    <= result_d;
            wraps_q     <= wraps_d;
            aborted_q   <= aborted_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Command-driven controller for the team's loadable up/down counter (ports D, clk, clr, enable, load, up, Q, Co).
- Accepts one command at a time over a valid/ready handshake: load a value, count up N steps, count down N steps, or clear.
- Drives the counter's control pins cycle-accurately.
- Returns the final Q and the number of terminal-count (Co) events, with a one-cycle done pulse.

Parameters:
- WIDTH, 4, width of counter data (D/Q), cmd_data, result and wraps.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous, active-high reset of this controller.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle and able to accept.
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- cmd_data  in  WIDTH  LOAD: value; UP/DOWN: step count N; CLEAR: ignored.
- cmd_abort  in  1  terminates an UP/DOWN in progress.
- cnt_D  out  WIDTH  to counter D.
- cnt_load  out  1  to counter load.
- cnt_enable  out  1  to counter enable.
- cnt_up  out  1  to counter up.
- cnt_clr_n  out  1  to counter clr (active-low clear).
- cnt_Q  in  WIDTH  from counter Q.
- cnt_Co  in  1  from counter Co.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  cnt_Q captured at completion.
- wraps  out  WIDTH  Co events during last UP/DOWN; saturates at all-ones.
- aborted  out  1  last command ended by cmd_abort.

Behaviour:
- Counter contract:
  - On a clk edge, enable=1 with load=1 loads D.
  - enable=1 with load=0 counts by ±1 and wraps modulo 2^WIDTH.
  - cnt_clr_n=0 clears Q to 0.
  - cnt_Co is combinationally high when enable=1, load=0, and either up=1 with Q=all-ones or up=0 with Q=0.
- Reset (clr=1 at an edge):
  - State goes to IDLE.
  - cnt_load=0, cnt_enable=0, cnt_up=0, cnt_clr_n=1, cnt_D=0.
  - done=0, result=0, wraps=0, aborted=0.
  - Applies mid-command: no done pulse is produced and the counter is left at its current value.
- All counter-control outputs are registered or decoded from registered state only (Moore). cmd_abort is the only combinational gate, and it gates cnt_enable.
- IDLE:
  - cmd_ready=1 and all counter controls inactive.
  - A handshake (cmd_valid & cmd_ready) at an edge captures op and data, clears the step counter and wraps accumulator, and sets aborted=0.
  - Next state: LOAD→LD; CLEAR→CL; UP/DOWN with N≠0→STEP; UP/DOWN with N=0→SETTLE.
- cmd_ready=0 in every state except IDLE. cmd_valid is ignored while busy.
- LD: cnt_enable=1, cnt_load=1, cnt_D=data for exactly one cycle, then SETTLE.
- CL: cnt_clr_n=0 for exactly one cycle, then SETTLE.
- STEP:
  - cnt_enable=1 (gated by !cmd_abort), cnt_load=0, cnt_up=1 for UP and 0 for DOWN.
  - Remaining count decrements each cycle.
  - A cycle with cnt_Co=1 and cnt_enable=1 increments wraps_acc (saturating).
  - Leaves to SETTLE after the N-th enabled cycle.
  - cmd_abort=1 in a STEP cycle: that cycle is not counted (enable=0), aborted is set, and the state goes to SETTLE.
- SETTLE:
  - All counter controls inactive for one cycle.
  - At exit edge: result←cnt_Q, wraps←wraps_acc, then DONE.
- DONE: done=1 for one cycle, then IDLE. cmd_ready returns the cycle after DONE.
- cmd_abort outside STEP has no effect.
- Latency, counted from the accepting edge to the cycle with done=1:
  - LOAD and CLEAR: 3 cycles.
  - UP/DOWN N≠0: N+2 cycles.
  - N=0: 2 cycles.
- Throughput: one command every latency+1 cycles.
- result/wraps/aborted hold their value until the next DONE or reset.

Test Plan:
- Reset, then LOAD 6 → cnt_load and cnt_enable high for exactly 1 cycle with cnt_D=6; done 3 cycles after accept; result=6, wraps=0, aborted=0.
- After LOAD 6, issue UP 4 → cnt_enable high for 4 consecutive cycles with cnt_up=1 and cnt_load=0; done at +6; result=10, wraps=0. Then DOWN 4 → result=6.
- LOAD 14, then UP 5 → Q sequence 15,0,1,2,3; result=3, wraps=1. LOAD 1, then DOWN 3 → result=14, wraps=1.
- LOAD 0, then UP 8 with cmd_abort high in the 4th STEP cycle → exactly 3 enabled cycles; result=3, aborted=1, done pulses once.
- UP 0 → no enable cycle, done 2 cycles after accept, result = current Q. CLEAR → cnt_clr_n low exactly 1 cycle, result=0. cmd_valid held high during a busy command → no second accept until cmd_ready=1.
- clr asserted in the 2nd STEP cycle of UP 5 → next cycle: state IDLE, cmd_ready=1, all counter controls inactive, done never pulses, result/wraps/aborted=0.
